packed_bit_loader_arb: RTL
==========================

// Module: packed_bit_loader_arb
// PURPOSE
// - Round-robin arbiter and sequencer that shares one WIDTH-bit packed register between
//   N_REQ serial bit requesters.
// - The register lives in an interface instance inside this block.
// - The granted requester streams one bit per clock, written LSB first into x[idx].
// - When all WIDTH bits are written, the word is presented with a valid/ready handshake.
//   The register is then re-arbitrated.
// PARAMETERS
// - WIDTH   8  width of shared packed register; number of bits per frame (>=2)
// - N_REQ   2  number of serial requesters (>=1)
// PORTS
// - i_clk    input   1              single clock; all state updates on posedge
// - i_rst_n  input   1              reset, asynchronous, active-low
// - i_req    input   N_REQ          per-requester frame request; held high for the whole frame
// - i_bit    input   N_REQ          per-requester serial data bit; sampled only while granted
// - o_gnt    output  N_REQ          one-hot grant; registered; high for the WIDTH load cycles
// - o_valid  output  1              completed word available
// - i_ready  input   1              consumer accepts word when o_valid & i_ready
// - o_data   output  WIDTH          shared packed register contents (interface x)
// - o_abort  output  1              one-cycle pulse: owner dropped i_req mid-load
// BEHAVIOUR
// - Reset values (async, i_rst_n low): state=IDLE, o_gnt=0, o_valid=0, o_abort=0,
//   o_data=0, idx=0, rr pointer=0.
// - FSM states and transitions:
//   - IDLE
//     - Any i_req high: pick the first requester at or after the rr pointer (cyclic).
//     - Set owner, o_gnt[owner]=1, idx=0; go to LOAD.
//   - LOAD
//     - Each cycle: x[idx] <= i_bit[owner]; idx <= idx+1.
//     - At idx==WIDTH-1: write the final bit, o_gnt=0, o_valid=1; go to HOLD.
//     - idx is $clog2(WIDTH) bits and never exceeds WIDTH-1. No out-of-range write occurs.
//   - HOLD
//     - o_valid=1 and o_data stable.
//     - On i_ready: o_valid=0, rr pointer=owner+1 (wraps at N_REQ); go to IDLE.
// - Timing and latency:
//   - i_req rises at edge k: o_gnt rises after edge k+1.
//   - The requester must present bit0 during the first cycle o_gnt is high.
//   - Bit j is captured at edge k+2+j.
//   - o_valid rises after edge k+1+WIDTH.
//   - Re-arbitration costs one IDLE cycle after the handshake.
// - Abort: i_req[owner] low while in LOAD.
//   - That cycle's bit is not written; o_gnt=0, o_abort=1 for one cycle.
//   - rr pointer=owner+1; go to IDLE.
//   - x keeps its partial contents and no o_valid is raised.
// - Requests from non-owners while in LOAD or HOLD are ignored; they wait and need no latching.
// - i_ready while o_valid=0 has no effect.
// - o_data always reflects x, so it changes during LOAD. It is meaningful only while o_valid=1.
// - Async reset asserted mid-LOAD or mid-HOLD: immediate return to reset values.
//   The partial word is discarded.
// STRUCTURE
// - Package packed_bit_loader_pkg:
//   - typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t
//   - default WIDTH/N_REQ localparams
//   - function next_rr(ptr, n)
// - Interface holding logic [WIDTH-1:0] x, instantiated internally.
//   All writes to x are made from one always_ff.
// - Sub-module rr_pick: combinational round-robin selector
//   (req vector, pointer -> one-hot grant, any).
// TESTING
// - Single frame: i_req[0]=1, bits 1,0,1,1,0,0,1,0 -> o_data=8'h4D, o_valid after 9 edges;
//   i_ready=1 -> IDLE.
// - Contention: i_req=2'b11 from reset -> grant 0 first.
//   After the handshake grant 1; after the next handshake grant 0 again.
// - Back-pressure: hold i_ready=0 for 5 cycles in HOLD.
//   o_data/o_valid stay stable; i_req[1] waits, o_gnt=0.
// - Abort: owner drops i_req after 3 bits -> o_abort one-cycle pulse, no o_valid;
//   the other requester is granted next.
// - Reset mid-LOAD at bit 4: all outputs 0 immediately.
//   The next frame loads a full 8 bits correctly from idx 0.
// - Idle ready: i_ready=1 with no frame -> no state change, o_valid stays 0.

Source files
------------

// File: rtl/packed_bit_loader_pkg.sv
// Shared types and helpers for the packed bit loader arbiter.
package packed_bit_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N_REQ = 2;

   // Round-robin successor of ptr over n requesters.
   function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/packed_bit_loader_arb_if.sv
// Holds the shared packed register that requesters load bit by bit.
interface packed_bit_loader_arb_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] x;

   modport master (output x);
   modport slave  (input  x);
endinterface

// File: rtl/packed_bit_loader_arb_rr_pick.sv
// Combinational round-robin selector: first request at or after ptr, cyclic.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int PW    = 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             any_o
);
   int j;

   // Walk offsets from farthest to nearest so the nearest winner overwrites.
   always_comb begin
      gnt_o = '0;
      j     = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = (int'(ptr_i) + i) % N_REQ;
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
         end
      end
   end

   assign any_o = |req_i;
endmodule

// File: rtl/packed_bit_loader_arb.sv
// Round-robin sequencer sharing one packed register between serial bit requesters.
module packed_bit_loader_arb
   import packed_bit_loader_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic [N_REQ-1:0] i_bit,
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_abort
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   packed_bit_loader_arb_if #(.WIDTH(WIDTH)) u_reg ();

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             valid_q, valid_d;
   logic             abort_q, abort_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [PW-1:0]    rr_q, rr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic             wr_en;

   logic [N_REQ-1:0] pick_gnt;
   logic             pick_any;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    rr_nxt;

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req_i (i_req),
      .ptr_i (rr_q),
      .gnt_o (pick_gnt),
      .any_o (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (pick_gnt[i]) pick_idx = PW'(i);
   end

   assign rr_nxt = PW'(next_rr(32'(owner_q), 32'(N_REQ)));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      abort_d = 1'b0;
      idx_d   = idx_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: if (pick_any) begin
            owner_d = pick_idx;
            gnt_d   = pick_gnt;
            idx_d   = '0;
            state_d = LOAD;
         end
         LOAD: if (!i_req[owner_q]) begin
            // Owner gave up mid-frame: keep partial x, hand the turn onward.
            gnt_d   = '0;
            abort_d = 1'b1;
            rr_d    = rr_nxt;
            state_d = IDLE;
         end else begin
            wr_en = 1'b1;
            if (idx_q == LAST) begin
               gnt_d   = '0;
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         HOLD: if (i_ready) begin
            valid_d = 1'b0;
            rr_d    = rr_nxt;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         abort_q <= 1'b0;
         idx_q   <= '0;
         rr_q    <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         abort_q <= abort_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   u_reg.x <= '0;
      else if (wr_en) u_reg.x[idx_q] <= i_bit[owner_q];
   end

   assign o_gnt   = gnt_q;
   assign o_valid = valid_q;
   assign o_abort = abort_q;
   assign o_data  = u_reg.x;
endmodule
